// File: rtl/bcd_digit_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_digit_counter_if
//   Bundles the button, load and digit/status signals of one BCD digit.
//   master : drives buttons and load (stimulus or upstream control)
//   slave  : the counter itself; drives digit bits a0..a3 and the
//            carry / borrow / load_err pulses
// ---------------------------------------------------------------------------
interface bcd_digit_counter_if;
    logic       btn_up;
    logic       btn_down;
    logic       load;
    logic [3:0] load_val;
    logic       a0;
    logic       a1;
    logic       a2;
    logic       a3;
    logic       carry;
    logic       borrow;
    logic       load_err;

    modport master (
        output btn_up, btn_down, load, load_val,
        input  a0, a1, a2, a3, carry, borrow, load_err
    );

    modport slave (
        input  btn_up, btn_down, load, load_val,
        output a0, a1, a2, a3, carry, borrow, load_err
    );
endinterface

// File: rtl/bcd_digit_counter.sv
// ---------------------------------------------------------------------------
// bcd_digit_counter
//   Single BCD digit (0..9) counted up/down by two debounced raw pushbuttons,
//   with a synchronous parallel load. carry/borrow pulse on wrap so digits
//   can be cascaded; load_err flags a load of a non-BCD value.
// Ports
//   clk  : rising-edge system clock
//   rst  : asynchronous, active-high reset
//   bus  : slave modport of bcd_digit_counter_if
//          in : btn_up, btn_down (raw, async), load, load_val[3:0]
//          out: a0..a3 (digit, a0 = LSB), carry, borrow, load_err (registered)
// ---------------------------------------------------------------------------
module bcd_digit_counter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DB_W            = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_digit_counter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        RELEASING = 2'd3
    } db_state_e;

    localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};
    localparam logic [DB_W-1:0] DB_ONE  = {{(DB_W-1){1'b0}}, 1'b1};
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Index 0 = up button, index 1 = down button throughout.
    logic [1:0]      sync1_r;
    logic [1:0]      sync2_r;
    db_state_e       state_r [2];
    db_state_e       state_s [2];
    logic [DB_W-1:0] cnt_r   [2];
    logic [DB_W-1:0] cnt_s   [2];
    logic [1:0]      press_s;
    logic [1:0]      press_r;

    logic [3:0]      digit_r;
    logic [3:0]      digit_s;
    logic            carry_r;
    logic            carry_s;
    logic            borrow_r;
    logic            borrow_s;
    logic            load_err_r;
    logic            load_err_s;

    // Two-flop synchroniser for the asynchronous pushbuttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= {bus.btn_down, bus.btn_up};
            sync2_r <= sync1_r;
        end
    end

    // Debounce FSM next state: a press qualifies only after DEBOUNCE_CYCLES
    // consecutive high samples, and must be released just as long before
    // another press can be recognised (no auto-repeat while held).
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_s[i] = state_r[i];
            cnt_s[i]   = cnt_r[i];
            press_s[i] = 1'b0;
            case (state_r[i])
                IDLE: begin
                    if (sync2_r[i]) begin
                        state_s[i] = ARMING;
                        cnt_s[i]   = DB_ONE;
                    end else begin
                        cnt_s[i]   = DB_ZERO;
                    end
                end
                ARMING: begin
                    if (!sync2_r[i]) begin
                        state_s[i] = IDLE;
                        cnt_s[i]   = DB_ZERO;
                    end else if (cnt_r[i] == DB_LAST) begin
                        state_s[i] = HELD;
                        cnt_s[i]   = DB_ZERO;
                        press_s[i] = 1'b1;
                    end else begin
                        cnt_s[i]   = cnt_r[i] + DB_ONE;
                    end
                end
                HELD: begin
                    if (!sync2_r[i]) begin
                        state_s[i] = RELEASING;
                        cnt_s[i]   = DB_ONE;
                    end else begin
                        cnt_s[i]   = DB_ZERO;
                    end
                end
                RELEASING: begin
                    if (sync2_r[i]) begin
                        state_s[i] = HELD;
                        cnt_s[i]   = DB_ZERO;
                    end else if (cnt_r[i] == DB_LAST) begin
                        state_s[i] = IDLE;
                        cnt_s[i]   = DB_ZERO;
                    end else begin
                        cnt_s[i]   = cnt_r[i] + DB_ONE;
                    end
                end
                default: begin
                    state_s[i] = IDLE;
                    cnt_s[i]   = DB_ZERO;
                end
            endcase
        end
    end

    // Debounce FSM state, counters and the registered one-cycle press pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                state_r[i] <= IDLE;
                cnt_r[i]   <= DB_ZERO;
            end
            press_r <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_r[i] <= state_s[i];
                cnt_r[i]   <= cnt_s[i];
            end
            press_r <= press_s;
        end
    end

    // Digit update: load beats buttons (pulses are simply dropped), and
    // simultaneous up/down presses cancel each other.
    always_comb begin
        digit_s    = digit_r;
        carry_s    = 1'b0;
        borrow_s   = 1'b0;
        load_err_s = 1'b0;
        if (bus.load) begin
            if (bus.load_val <= 4'd9) begin
                digit_s    = bus.load_val;
            end else begin
                load_err_s = 1'b1;
            end
        end else if (press_r[0] && press_r[1]) begin
            digit_s = digit_r;
        end else if (press_r[0]) begin
            if (digit_r == 4'd9) begin
                digit_s = 4'd0;
                carry_s = 1'b1;
            end else begin
                digit_s = digit_r + 4'd1;
            end
        end else if (press_r[1]) begin
            if (digit_r == 4'd0) begin
                digit_s  = 4'd9;
                borrow_s = 1'b1;
            end else begin
                digit_s  = digit_r - 4'd1;
            end
        end else begin
            digit_s = digit_r;
        end
    end

    // Digit and status pulses; the pulses line up with the new digit value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_r    <= 4'd0;
            carry_r    <= 1'b0;
            borrow_r   <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            digit_r    <= digit_s;
            carry_r    <= carry_s;
            borrow_r   <= borrow_s;
            load_err_r <= load_err_s;
        end
    end

    assign bus.a0       = digit_r[0];
    assign bus.a1       = digit_r[1];
    assign bus.a2       = digit_r[2];
    assign bus.a3       = digit_r[3];
    assign bus.carry    = carry_r;
    assign bus.borrow   = borrow_r;
    assign bus.load_err = load_err_r;

endmodule

// File: tb/tb_bcd_digit_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_digit_counter
//   Directed bench for bcd_digit_counter with DEBOUNCE_CYCLES = 4, so a clean
//   press changes the digit on the 7th rising edge after the button goes high.
//   Observed outputs are packed as {digit, carry, borrow, load_err}.
// ---------------------------------------------------------------------------
module tb_bcd_digit_counter;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    bcd_digit_counter_if bus ();

    bcd_digit_counter #(
        .DEBOUNCE_CYCLES (4),
        .DB_W            (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {bus.a3, bus.a2, bus.a1, bus.a0, bus.carry, bus.borrow, bus.load_err};
    endfunction

    function automatic logic [6:0] exp_v(input logic [3:0] d, input logic c,
                                         input logic b, input logic e);
        return {d, c, b, e};
    endfunction

    task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got digit=%0d c/b/e=%b expected digit=%0d c/b/e=%b",
                     tag, got[6:3], got[2:0], exp[6:3], exp[2:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_load(input logic [3:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        tick();
        bus.load     = 1'b0;
        bus.load_val = 4'd0;
    endtask

    // Drive buttons high; the change must land exactly on the 7th edge.
    task automatic press(input logic up, input logic dn, input string tag,
                         input logic [3:0] d_before, input logic [6:0] exp_after);
        bus.btn_up   = up;
        bus.btn_down = dn;
        ticks(6);
        check_eq({tag, "_pre"}, obs(), exp_v(d_before, 1'b0, 1'b0, 1'b0));
        tick();
        check_eq({tag, "_edge7"}, obs(), exp_after);
    endtask

    task automatic release_all();
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        ticks(8);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 4'd0;
        ticks(3);
        rst = 1'b0;
        tick();
        check_eq("reset", obs(), exp_v(4'd0, 1'b0, 1'b0, 1'b0));

        // Clean up press held 20 cycles: one increment, no repeat.
        press(1'b1, 1'b0, "up1", 4'd0, exp_v(4'd1, 1'b0, 1'b0, 1'b0));
        ticks(13);
        check_eq("up1_held", obs(), exp_v(4'd1, 1'b0, 1'b0, 1'b0));
        release_all();
        check_eq("up1_released", obs(), exp_v(4'd1, 1'b0, 1'b0, 1'b0));

        // Bounce 1,0,1,0 is rejected.
        bus.btn_up = 1'b1; tick();
        bus.btn_up = 1'b0; tick();
        bus.btn_up = 1'b1; tick();
        bus.btn_up = 1'b0;
        ticks(10);
        check_eq("bounce", obs(), exp_v(4'd1, 1'b0, 1'b0, 1'b0));

        // Load 9, then up wraps to 0 with a single-cycle carry.
        do_load(4'd9);
        check_eq("load9", obs(), exp_v(4'd9, 1'b0, 1'b0, 1'b0));
        press(1'b1, 1'b0, "wrap_up", 4'd9, exp_v(4'd0, 1'b1, 1'b0, 1'b0));
        tick();
        check_eq("carry_drop", obs(), exp_v(4'd0, 1'b0, 1'b0, 1'b0));
        release_all();

        // Down from 0 wraps to 9 with a single-cycle borrow.
        press(1'b0, 1'b1, "wrap_dn", 4'd0, exp_v(4'd9, 1'b0, 1'b1, 1'b0));
        tick();
        check_eq("borrow_drop", obs(), exp_v(4'd9, 1'b0, 1'b0, 1'b0));
        release_all();

        // 8 -> 9 is a plain increment.
        do_load(4'd8);
        check_eq("load8", obs(), exp_v(4'd8, 1'b0, 1'b0, 1'b0));
        press(1'b1, 1'b0, "up8", 4'd8, exp_v(4'd9, 1'b0, 1'b0, 1'b0));
        release_all();

        // 3 -> 2 is a plain decrement.
        do_load(4'd3);
        press(1'b0, 1'b1, "dn3", 4'd3, exp_v(4'd2, 1'b0, 1'b0, 1'b0));
        release_all();

        // Simultaneous up and down pulses cancel.
        do_load(4'd9);
        press(1'b1, 1'b1, "both", 4'd9, exp_v(4'd9, 1'b0, 1'b0, 1'b0));
        tick();
        check_eq("both_after", obs(), exp_v(4'd9, 1'b0, 1'b0, 1'b0));
        release_all();

        // Out-of-range load holds the digit and flags load_err for one cycle.
        do_load(4'd12);
        check_eq("load12", obs(), exp_v(4'd9, 1'b0, 1'b0, 1'b1));
        tick();
        check_eq("load_err_drop", obs(), exp_v(4'd9, 1'b0, 1'b0, 1'b0));
        do_load(4'd15);
        check_eq("load15", obs(), exp_v(4'd9, 1'b0, 1'b0, 1'b1));

        // Reset while up is ARMING at digit 5; held button must requalify.
        do_load(4'd5);
        check_eq("load5", obs(), exp_v(4'd5, 1'b0, 1'b0, 1'b0));
        bus.btn_up = 1'b1;
        ticks(3);
        rst = 1'b1;
        #1;
        check_eq("rst_async", obs(), exp_v(4'd0, 1'b0, 1'b0, 1'b0));
        ticks(2);
        rst = 1'b0;
        ticks(6);
        check_eq("requal_pre", obs(), exp_v(4'd0, 1'b0, 1'b0, 1'b0));
        tick();
        check_eq("requal_edge7", obs(), exp_v(4'd1, 1'b0, 1'b0, 1'b0));
        release_all();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
